// File: rtl/or1200_vlx_pkg.sv
// Shared types and constants for the OR1200 VLX store-path controller.
// OR1200_VLX_STUFF_EN (in or1200_vlx_ctrl) enables 0x00 stuffing after 0xFF bytes.
package or1200_vlx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STUFF = 2'd2
    } vlx_state_t;

    localparam int         VLX_ACC_W   = 32;
    localparam logic [4:0] VLX_MAX_LEN = 5'd16;
    localparam logic [7:0] VLX_MARKER  = 8'hFF;
    localparam logic [7:0] VLX_STUFF   = 8'h00;

endpackage

// File: rtl/or1200_vlx_bitpack.sv
// Combinational put path: saturates the field length, masks the value and
// aligns it MSB-first just below the current fill point of the accumulator.
module or1200_vlx_bitpack
    import or1200_vlx_pkg::*;
(
    input  logic                 valid,
    input  logic [15:0]          val,
    input  logic [4:0]           len,
    input  logic [VLX_ACC_W-1:0] acc,
    input  logic [5:0]           cnt,
    output logic [VLX_ACC_W-1:0] acc_nxt,
    output logic [5:0]           cnt_nxt
);

    logic [4:0]           len_sat;
    logic [16:0]          mask;
    logic [15:0]          field;
    logic [VLX_ACC_W-1:0] field_left;
    logic [VLX_ACC_W-1:0] field_pos;

    always_comb begin
        len_sat    = (len > VLX_MAX_LEN) ? VLX_MAX_LEN : len;
        mask       = (17'd1 << len_sat) - 17'd1;
        field      = val & mask[15:0];
        // left-align the field at bit 31, then drop it below the already filled bits
        field_left = {field, 16'h0000} << (VLX_MAX_LEN - len_sat);
        field_pos  = field_left >> cnt;
        acc_nxt    = valid ? (acc | field_pos) : acc;
        cnt_nxt    = valid ? (cnt + {1'b0, len_sat}) : cnt;
    end

endmodule

// File: rtl/or1200_vlx_ctrl.sv
// VLX store-path sequencer: bit accumulator, byte hand-off to the store unit,
// flush padding/drain. OR1200_VLX_STUFF_EN adds JPEG 0x00 stuffing after 0xFF.
module or1200_vlx_ctrl
    import or1200_vlx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vlx_valid_i,
    input  logic [15:0] vlx_val_i,
    input  logic [4:0]  vlx_len_i,
    input  logic        flush_i,
    input  logic        set_addr_i,
    input  logic [31:0] addr_i,
    input  logic        su_ack_i,
    output logic        su_store_byte_o,
    output logic        su_set_init_addr_o,
    output logic [31:0] su_dat_o,
    output logic        su_last_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [5:0]  bit_cnt_o
);

    vlx_state_t           state;
    logic [VLX_ACC_W-1:0] acc;
    logic [5:0]           cnt;
    logic                 flush_pend;

    logic [VLX_ACC_W-1:0] acc_nxt;
    logic [5:0]           cnt_nxt;
    logic [5:0]           cnt_pad;
    logic [VLX_ACC_W-1:0] pad_mask;
    logic [VLX_ACC_W-1:0] acc_flush;
    logic                 stuff_hit;

    or1200_vlx_bitpack u_bitpack (
        .valid   (vlx_valid_i),
        .val     (vlx_val_i),
        .len     (vlx_len_i),
        .acc     (acc),
        .cnt     (cnt),
        .acc_nxt (acc_nxt),
        .cnt_nxt (cnt_nxt)
    );

    assign stall_o   = (state != IDLE) || (cnt >= 6'd8);
    assign bit_cnt_o = cnt;

    // padding is computed on the post-put fill so a same-cycle put+flush packs first
    assign cnt_pad   = {cnt_nxt[5:3] + {2'b00, |cnt_nxt[2:0]}, 3'b000};
    assign pad_mask  = (32'hFFFF_FFFF >> cnt_nxt) & ~(32'hFFFF_FFFF >> cnt_pad);
    assign acc_flush = acc_nxt | pad_mask;

`ifdef OR1200_VLX_STUFF_EN
    assign stuff_hit = (acc[31:24] == VLX_MARKER);
`else
    assign stuff_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= IDLE;
            acc                <= '0;
            cnt                <= '0;
            flush_pend         <= 1'b0;
            su_store_byte_o    <= 1'b0;
            su_set_init_addr_o <= 1'b0;
            su_dat_o           <= '0;
            su_last_o          <= 1'b0;
            done_o             <= 1'b0;
        end else begin
            done_o             <= 1'b0;
            su_set_init_addr_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cnt >= 6'd8) begin
                        state           <= REQ;
                        su_store_byte_o <= 1'b1;
                        su_dat_o        <= {24'h0, acc[31:24]};
                        // when a stuff byte follows, it carries the last flag instead
                        su_last_o       <= flush_pend && (cnt == 6'd8) && !stuff_hit;
                    end else begin
                        if (flush_i) begin
                            acc        <= acc_flush;
                            cnt        <= cnt_pad;
                            flush_pend <= 1'b1;
                        end else begin
                            acc <= acc_nxt;
                            cnt <= cnt_nxt;
                            if (flush_pend && (cnt == 6'd0))
                                flush_pend <= 1'b0;
                        end
                        if (flush_pend && (cnt == 6'd0))
                            done_o <= 1'b1;
                        if (set_addr_i) begin
                            su_set_init_addr_o <= 1'b1;
                            su_dat_o           <= addr_i;
                        end else begin
                            su_dat_o <= '0;
                        end
                    end
                end
                REQ: begin
                    if (su_ack_i) begin
                        su_store_byte_o <= 1'b0;
                        su_last_o       <= 1'b0;
                        su_dat_o        <= '0;
                        acc             <= acc << 8;
                        cnt             <= cnt - 6'd8;
                        state           <= stuff_hit ? STUFF : IDLE;
                    end
                end
`ifdef OR1200_VLX_STUFF_EN
                STUFF: begin
                    // request drops for a cycle after the marker ack, then re-rises with 0x00
                    if (!su_store_byte_o) begin
                        su_store_byte_o <= 1'b1;
                        su_dat_o        <= {24'h0, VLX_STUFF};
                        su_last_o       <= flush_pend && (cnt == 6'd0);
                    end else if (su_ack_i) begin
                        su_store_byte_o <= 1'b0;
                        su_last_o       <= 1'b0;
                        su_dat_o        <= '0;
                        state           <= IDLE;
                    end
                end
`endif
                default: begin
                    state           <= IDLE;
                    su_store_byte_o <= 1'b0;
                    su_last_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or1200_vlx_ctrl.sv
// Directed bench for or1200_vlx_ctrl with a hand-driven store-unit ack.
module tb_or1200_vlx_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        vlx_valid_i;
    logic [15:0] vlx_val_i;
    logic [4:0]  vlx_len_i;
    logic        flush_i;
    logic        set_addr_i;
    logic [31:0] addr_i;
    logic        su_ack_i;
    logic        su_store_byte_o;
    logic        su_set_init_addr_o;
    logic [31:0] su_dat_o;
    logic        su_last_o;
    logic        stall_o;
    logic        done_o;
    logic [5:0]  bit_cnt_o;

    int checks   = 0;
    int failures = 0;

    or1200_vlx_ctrl dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .vlx_valid_i        (vlx_valid_i),
        .vlx_val_i          (vlx_val_i),
        .vlx_len_i          (vlx_len_i),
        .flush_i            (flush_i),
        .set_addr_i         (set_addr_i),
        .addr_i             (addr_i),
        .su_ack_i           (su_ack_i),
        .su_store_byte_o    (su_store_byte_o),
        .su_set_init_addr_o (su_set_init_addr_o),
        .su_dat_o           (su_dat_o),
        .su_last_o          (su_last_o),
        .stall_o            (stall_o),
        .done_o             (done_o),
        .bit_cnt_o          (bit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        vlx_valid_i = 1'b0;
        vlx_val_i   = '0;
        vlx_len_i   = '0;
        flush_i     = 1'b0;
        set_addr_i  = 1'b0;
        addr_i      = '0;
        su_ack_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic put(input logic [15:0] v, input logic [4:0] l, input logic fl);
        vlx_valid_i = 1'b1;
        vlx_val_i   = v;
        vlx_len_i   = l;
        flush_i     = fl;
        @(negedge clk_i);
        vlx_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic expect_store(input string tag, input logic [7:0] b, input logic last, input int lat);
        int n = 0;
        while (su_store_byte_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_req"}, {31'b0, su_store_byte_o}, 32'd1);
        check({tag, "_dat"}, su_dat_o, {24'h0, b});
        check({tag, "_last"}, {31'b0, su_last_o}, {31'b0, last});
        repeat (lat) @(negedge clk_i);
        if (lat > 0)
            check({tag, "_hold"}, {su_store_byte_o, su_dat_o[30:0]}, {1'b1, 23'h0, b});
        su_ack_i = 1'b1;
        @(negedge clk_i);
        su_ack_i = 1'b0;
        check({tag, "_drop"}, {31'b0, su_store_byte_o}, 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int ncyc);
        logic seen = 1'b0;
        repeat (ncyc) begin
            @(negedge clk_i);
            seen = seen | su_store_byte_o;
        end
        check({tag, "_quiet"}, {31'b0, seen}, 32'd0);
    endtask

    task automatic expect_done(input string tag);
        int n = 0;
        while (done_o !== 1'b1 && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_done"}, {31'b0, done_o}, 32'd1);
        @(negedge clk_i);
        check({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_cnt", {26'h0, bit_cnt_o}, 32'd0);
        check("rst_stall", {31'b0, stall_o}, 32'd0);
        check("rst_store", {31'b0, su_store_byte_o}, 32'd0);

        // reset while a store is waiting on ack
        put(16'h0012, 5'd8, 1'b0);
        begin
            int n = 0;
            while (su_store_byte_o !== 1'b1 && n < 10) begin
                @(negedge clk_i);
                n++;
            end
        end
        check("pend_req", {31'b0, su_store_byte_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("arst_outs", {su_store_byte_o, su_set_init_addr_o, su_last_o, stall_o, done_o},
              32'd0);
        check("arst_dat", su_dat_o, 32'd0);
        check("arst_cnt", {26'h0, bit_cnt_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        expect_quiet("arst", 6);

        // 101 + 11111 -> 0xBF
        put(16'h0005, 5'd3, 1'b0);
        check("p3_cnt", {26'h0, bit_cnt_o}, 32'd3);
        put(16'h001F, 5'd5, 1'b0);
        expect_store("bf", 8'hBF, 1'b0, 2);
        check("bf_cnt", {26'h0, bit_cnt_o}, 32'd0);
        expect_quiet("bf", 4);

        // 1010 + 1010_1011_1100_1101 -> AA, BC, leftover nibble; stalled put ignored
        put(16'h000A, 5'd4, 1'b0);
        put(16'hABCD, 5'd16, 1'b0);
        check("p20_cnt", {26'h0, bit_cnt_o}, 32'd20);
        check("p20_stall", {31'b0, stall_o}, 32'd1);
        put(16'h0001, 5'd4, 1'b0);
        expect_store("aa", 8'hAA, 1'b0, 0);
        expect_store("bc", 8'hBC, 1'b0, 1);
        expect_quiet("bc", 3);
        check("rem_cnt", {26'h0, bit_cnt_o}, 32'd4);
        check("rem_stall", {31'b0, stall_o}, 32'd0);

        // marker byte
        do_reset();
        put(16'h00FF, 5'd8, 1'b0);
        expect_store("ff", 8'hFF, 1'b0, 0);
`ifdef OR1200_VLX_STUFF_EN
        expect_store("ff_stuff", 8'h00, 1'b0, 1);
`endif
        expect_quiet("ff", 4);

        // put + flush in the same cycle: 10 padded with 1s -> 0xBF, last
        do_reset();
        put(16'h0002, 5'd2, 1'b1);
        expect_store("fl", 8'hBF, 1'b1, 0);
        expect_done("fl");
        expect_quiet("fl", 3);
        check("fl_cnt", {26'h0, bit_cnt_o}, 32'd0);

        // flush with nothing buffered
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        expect_done("fl0");
        expect_quiet("fl0", 3);

        // len 0 is a no-op
        put(16'h0007, 5'd0, 1'b0);
        check("len0_cnt", {26'h0, bit_cnt_o}, 32'd0);
        expect_quiet("len0", 3);

        // len 31 saturates to 16
        put(16'hFFFF, 5'd31, 1'b0);
        check("len31_cnt", {26'h0, bit_cnt_o}, 32'd16);
        expect_store("l31a", 8'hFF, 1'b0, 0);
`ifdef OR1200_VLX_STUFF_EN
        expect_store("l31a_stuff", 8'h00, 1'b0, 0);
`endif
        expect_store("l31b", 8'hFF, 1'b0, 0);
`ifdef OR1200_VLX_STUFF_EN
        expect_store("l31b_stuff", 8'h00, 1'b0, 0);
`endif
        expect_quiet("len31", 3);
        check("len31_end", {26'h0, bit_cnt_o}, 32'd0);

        // upper value bits masked: 111 + 00000 -> 0xE0
        put(16'hFFFF, 5'd3, 1'b0);
        put(16'h0000, 5'd5, 1'b0);
        expect_store("mask", 8'hE0, 1'b0, 0);

        // final marker of a flush: last flag rides on the stuff byte when enabled
        put(16'h003F, 5'd6, 1'b1);
`ifdef OR1200_VLX_STUFF_EN
        expect_store("flff", 8'hFF, 1'b0, 0);
        expect_store("flff_stuff", 8'h00, 1'b1, 0);
`else
        expect_store("flff", 8'hFF, 1'b1, 0);
`endif
        expect_done("flff");

        // address load pulse
        set_addr_i = 1'b1;
        addr_i     = 32'h8000_1000;
        @(negedge clk_i);
        set_addr_i = 1'b0;
        addr_i     = 32'h0;
        check("addr_pulse", {31'b0, su_set_init_addr_o}, 32'd1);
        check("addr_dat", su_dat_o, 32'h8000_1000);
        @(negedge clk_i);
        check("addr_once", {31'b0, su_set_init_addr_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
